// File: rtl/kvdecompressor_core.sv
// INT8 -> INT16 KV-cache dequantizer: reads packed INT8 words over OBI, applies (b - zp) * scale >>> 8, writes INT16 pairs.
// Optional macro KVDECOMP_SAT_EN: saturate results to INT16 range instead of wrapping modulo 2^16.
module kvdecompressor_core #(
  parameter int VECTOR_MAX_LEN = 512
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] scale_i,
  input  logic [31:0] zp_i,
  input  logic [31:0] src_addr_i,
  input  logic [31:0] dst_addr_i,
  input  logic [31:0] length_i,
  input  logic        int_en_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic        irq_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_be_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic        mem_err_i,
  input  logic [31:0] mem_rdata_i
);

  localparam int LW = $clog2(VECTOR_MAX_LEN + 1);

  typedef enum logic [2:0] {
    IDLE, READ_REQ, READ_WAIT, WR_LO_REQ, WR_LO_WAIT, WR_HI_REQ, WR_HI_WAIT, FINISH
  } state_t;

  state_t        state;
  logic [15:0]   scale_q;
  logic [7:0]    zp_q;
  logic [LW-1:0] len_q;
  logic [LW-1:0] count_q;
  logic [31:0]   src_off_q;
  logic [31:0]   dst_off_q;
  logic [31:0]   word_q;

  logic [LW-1:0] len_clamped;
  logic [LW-1:0] remaining;
  logic [LW-1:0] step;
  logic [LW-1:0] count_next;
  logic [LW-1:0] rem_next;
  logic [31:0]   src_base;
  logic [31:0]   dst_base;
  logic [15:0]   y_rd0, y_rd1, y_w2, y_w3;
  logic          unused_bits;

  function automatic logic [15:0] dequant(input logic [7:0] b, input logic [7:0] zp,
                                          input logic [15:0] scale);
    logic signed [8:0]  d;
    logic signed [25:0] p;
    logic signed [25:0] sh;
    d  = $signed({b[7], b}) - $signed({zp[7], zp});
    p  = $signed({{17{d[8]}}, d}) * $signed({10'b0, scale});
    sh = p >>> 8;
`ifdef KVDECOMP_SAT_EN
    if (sh > 26'sd32767)       return 16'h7FFF;
    else if (sh < -26'sd32768) return 16'h8000;
    else                       return sh[15:0];
`else
    return 16'(sh);
`endif
  endfunction

  assign len_clamped = (length_i > 32'(VECTOR_MAX_LEN)) ? LW'(VECTOR_MAX_LEN) : length_i[LW-1:0];
  assign remaining   = len_q - count_q;
  assign step        = (remaining >= LW'(2)) ? LW'(2) : remaining;
  assign count_next  = count_q + step;
  assign rem_next    = len_q - count_next;
  assign src_base    = {src_addr_i[31:2], 2'b00};
  assign dst_base    = {dst_addr_i[31:2], 2'b00};

  // The low pair is produced straight from the bus so the write can follow the read response immediately.
  assign y_rd0 = dequant(mem_rdata_i[7:0],   zp_q, scale_q);
  assign y_rd1 = dequant(mem_rdata_i[15:8],  zp_q, scale_q);
  assign y_w2  = dequant(word_q[23:16],      zp_q, scale_q);
  assign y_w3  = dequant(word_q[31:24],      zp_q, scale_q);

  assign irq_o       = done_o & int_en_i;
  assign unused_bits = ^{scale_i[31:16], zp_i[31:8], src_addr_i[1:0], dst_addr_i[1:0]};

  // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      mem_be_o    <= 4'hF;
      scale_q     <= '0;
      zp_q        <= '0;
      len_q       <= '0;
      count_q     <= '0;
      src_off_q   <= '0;
      dst_off_q   <= '0;
      word_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            scale_q   <= scale_i[15:0];
            zp_q      <= zp_i[7:0];
            len_q     <= len_clamped;
            count_q   <= '0;
            src_off_q <= '0;
            dst_off_q <= '0;
            err_o     <= 1'b0;
            if (len_clamped == '0) begin
              state  <= FINISH;
              done_o <= 1'b1;
            end else begin
              state      <= READ_REQ;
              busy_o     <= 1'b1;
              mem_req_o  <= 1'b1;
              mem_we_o   <= 1'b0;
              mem_be_o   <= 4'hF;
              mem_addr_o <= src_base;
            end
          end
        end

        READ_REQ: begin
          if (mem_gnt_i) begin
            state     <= READ_WAIT;
            mem_req_o <= 1'b0;
          end
        end

        READ_WAIT: begin
          if (mem_rvalid_i) begin
            word_q    <= mem_rdata_i;
            src_off_q <= src_off_q + 32'd4;
            if (mem_err_i) begin
              err_o  <= 1'b1;
              state  <= FINISH;
              busy_o <= 1'b0;
              done_o <= 1'b1;
            end else begin
              state       <= WR_LO_REQ;
              mem_req_o   <= 1'b1;
              mem_we_o    <= 1'b1;
              mem_addr_o  <= dst_base + dst_off_q;
              mem_wdata_o <= {y_rd1, y_rd0};
              mem_be_o    <= (remaining >= LW'(2)) ? 4'hF : 4'h3;
            end
          end
        end

        WR_LO_REQ: begin
          if (mem_gnt_i) begin
            state     <= WR_LO_WAIT;
            mem_req_o <= 1'b0;
          end
        end

        WR_LO_WAIT: begin
          if (mem_rvalid_i) begin
            dst_off_q <= dst_off_q + 32'd4;
            count_q   <= count_next;
            if (mem_err_i) begin
              err_o  <= 1'b1;
              state  <= FINISH;
              busy_o <= 1'b0;
              done_o <= 1'b1;
            end else if (rem_next != '0) begin
              state       <= WR_HI_REQ;
              mem_req_o   <= 1'b1;
              mem_we_o    <= 1'b1;
              mem_addr_o  <= dst_base + dst_off_q + 32'd4;
              mem_wdata_o <= {y_w3, y_w2};
              mem_be_o    <= (rem_next >= LW'(2)) ? 4'hF : 4'h3;
            end else begin
              state  <= FINISH;
              busy_o <= 1'b0;
              done_o <= 1'b1;
            end
          end
        end

        WR_HI_REQ: begin
          if (mem_gnt_i) begin
            state     <= WR_HI_WAIT;
            mem_req_o <= 1'b0;
          end
        end

        WR_HI_WAIT: begin
          if (mem_rvalid_i) begin
            dst_off_q <= dst_off_q + 32'd4;
            count_q   <= count_next;
            if (mem_err_i) begin
              err_o  <= 1'b1;
              state  <= FINISH;
              busy_o <= 1'b0;
              done_o <= 1'b1;
            end else if (rem_next != '0) begin
              // src_off_q was already advanced when the previous read completed.
              state      <= READ_REQ;
              mem_req_o  <= 1'b1;
              mem_we_o   <= 1'b0;
              mem_be_o   <= 4'hF;
              mem_addr_o <= src_base + src_off_q;
            end else begin
              state  <= FINISH;
              busy_o <= 1'b0;
              done_o <= 1'b1;
            end
          end
        end

        FINISH: begin
          if (!start_i) begin
            state  <= IDLE;
            done_o <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_kvdecompressor_core.sv
// Scoreboard bench for kvdecompressor_core: stimulus queues expected bus requests, a monitor pops and compares them.
module tb_kvdecompressor_core;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } txn_t;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [31:0] scale_i, zp_i, src_addr_i, dst_addr_i, length_i;
  logic        int_en_i;
  logic        busy_o, done_o, err_o, irq_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_gnt_i, mem_rvalid_i, mem_err_i;
  logic [31:0] mem_rdata_i;

  txn_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cycles;
  logic        first_req, first_err;
  logic [31:0] rd_data = 32'h0;
  logic        rd_err = 1'b0;
  logic        wr_err = 1'b0;
  int          stall_wr = 0;

  kvdecompressor_core dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .scale_i(scale_i), .zp_i(zp_i), .src_addr_i(src_addr_i), .dst_addr_i(dst_addr_i),
    .length_i(length_i), .int_en_i(int_en_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .irq_o(irq_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_err_i(mem_err_i),
    .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be);
    txn_t t;
    t.we = we; t.addr = addr; t.wdata = wdata; t.be = be;
    exp_q.push_back(t);
  endtask

  // Memory responder: grants at the next edge (writes may be stalled), answers one cycle after the grant.
  initial begin : responder
    int   wait_cnt;
    logic last_we;
    wait_cnt = 0;
    last_we = 1'b0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_err_i = 1'b0; mem_rdata_i = 32'h0;
    forever begin
      @(negedge clk_i);
      mem_rvalid_i = mem_gnt_i;
      mem_err_i    = mem_gnt_i && (last_we ? wr_err : rd_err);
      mem_rdata_i  = (mem_gnt_i && !last_we) ? rd_data : 32'hDEAD_BEEF;
      if (mem_req_o && (!mem_we_o || wait_cnt >= stall_wr)) begin
        mem_gnt_i = 1'b1;
        wait_cnt  = 0;
      end else begin
        mem_gnt_i = 1'b0;
        wait_cnt  = mem_req_o ? wait_cnt + 1 : 0;
      end
      last_we = mem_we_o;
    end
  end

  // Monitor: every new request is popped against the scoreboard; a stalled request must hold its fields.
  initial begin : monitor
    logic        in_req;
    logic [67:0] cap;
    txn_t        e;
    in_req = 1'b0;
    cap = '0;
    forever begin
      @(negedge clk_i);
      #1;
      if (mem_req_o) begin
        if (!in_req) begin
          in_req = 1'b1;
          cap = {mem_be_o, mem_addr_o, mem_wdata_o};
          check("req_expected", 80'(exp_q.size() != 0), 80'(1));
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check(e.we ? "write_txn" : "read_txn",
                  80'({mem_we_o, mem_be_o, mem_addr_o, e.we ? mem_wdata_o : 32'h0}),
                  80'({e.we, e.be, e.addr, e.we ? e.wdata : 32'h0}));
          end
        end else begin
          check("stall_stable", 80'({mem_be_o, mem_addr_o, mem_wdata_o}), 80'(cap));
        end
        if (mem_gnt_i) in_req = 1'b0;
      end else begin
        in_req = 1'b0;
      end
    end
  end

  task automatic run_job(input logic [31:0] sc, input logic [31:0] zp, input logic [31:0] src,
                         input logic [31:0] dst, input logic [31:0] len, input logic ien);
    scale_i = sc; zp_i = zp; src_addr_i = src; dst_addr_i = dst; length_i = len;
    int_en_i = ien; start_i = 1'b1;
    cycles = 0;
    do begin
      @(negedge clk_i);
      cycles++;
      if (cycles == 1) begin
        first_req = mem_req_o;
        first_err = err_o;
      end
    end while (!done_o && cycles < 3000);
    check("job_done", 80'(done_o), 80'(1));
  endtask

  task automatic end_job();
    start_i = 1'b0;
    @(negedge clk_i);
    check("back_to_idle", 80'({busy_o, done_o, irq_o}), 80'(0));
    check("queue_drained", 80'(exp_q.size()), 80'(0));
  endtask

  task automatic check_reset_state(input string name);
    check(name, 80'({busy_o, done_o, err_o, irq_o, mem_req_o, mem_we_o, mem_be_o}), 80'(10'b000000_1111));
    check({name, "_bus"}, 80'({mem_addr_o, mem_wdata_o}), 80'(0));
  endtask

  initial begin : stimulus
    rst_i = 1'b1; start_i = 1'b0; int_en_i = 1'b0;
    scale_i = '0; zp_i = '0; src_addr_i = '0; dst_addr_i = '0; length_i = '0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    check_reset_state("reset_state");

    // Unit scale, full word: bytes FF,01,7F,80 -> FFFF,0001,007F,FF80.
    rd_data = 32'h807F_01FF;
    push(1'b0, 32'h1000, 32'h0, 4'hF);
    push(1'b1, 32'h2000, 32'h0001_FFFF, 4'hF);
    push(1'b1, 32'h2004, 32'hFF80_007F, 4'hF);
    run_job(32'h0000_0100, 32'h0, 32'h1000, 32'h2000, 32'd4, 1'b1);
    check("first_req_latency", 80'(first_req), 80'(1));
    check("word_cycles", 80'(cycles), 80'(7));
    check("status_len4", 80'({busy_o, err_o, irq_o}), 80'(3'b001));
    end_job();

    // Odd length with misaligned source base; irq masked.
    push(1'b0, 32'h1000, 32'h0, 4'hF);
    push(1'b1, 32'h3000, 32'h0001_FFFF, 4'hF);
    push(1'b1, 32'h3004, 32'hFF80_007F, 4'h3);
    run_job(32'h0000_0100, 32'h0, 32'h1003, 32'h3000, 32'd3, 1'b0);
    check("status_len3", 80'({busy_o, err_o, irq_o}), 80'(3'b000));
    end_job();

    // Max scale, zp=-128: byte0 7F -> 255*65535>>>8 = 0xFEFF (saturates to 0x7FFF); byte1 00 -> 0x7FFF.
    rd_data = 32'h0000_007F;
    push(1'b0, 32'h4000, 32'h0, 4'hF);
`ifdef KVDECOMP_SAT_EN
    push(1'b1, 32'h5000, 32'h7FFF_7FFF, 4'h3);
`else
    push(1'b1, 32'h5000, 32'h7FFF_FEFF, 4'h3);
`endif
    run_job(32'h1234_FFFF, 32'hABCD_EF80, 32'h4000, 32'h5000, 32'd1, 1'b1);
    end_job();

    // Zero length: no bus traffic, done the cycle after start.
    run_job(32'h0000_0100, 32'h0, 32'h1000, 32'h2000, 32'd0, 1'b1);
    check("len0_no_req", 80'(first_req), 80'(0));
    check("len0_cycles", 80'(cycles), 80'(1));
    check("len0_irq", 80'(irq_o), 80'(1));
    end_job();

    // Bus error on the first read: no writes, sticky err until the next start.
    rd_err = 1'b1;
    push(1'b0, 32'h6000, 32'h0, 4'hF);
    run_job(32'h0000_0100, 32'h0, 32'h6000, 32'h7000, 32'd8, 1'b0);
    check("read_err_flag", 80'({err_o, busy_o}), 80'(2'b10));
    end_job();
    rd_err = 1'b0;
    rd_data = 32'h807F_01FF;
    push(1'b0, 32'h1000, 32'h0, 4'hF);
    push(1'b1, 32'h2000, 32'h0001_FFFF, 4'hF);
    push(1'b1, 32'h2004, 32'hFF80_007F, 4'hF);
    run_job(32'h0000_0100, 32'h0, 32'h1000, 32'h2000, 32'd4, 1'b0);
    check("err_cleared_on_start", 80'(first_err), 80'(0));
    check("err_stays_clear", 80'(err_o), 80'(0));
    end_job();

    // Length above the limit is clamped to 512 samples = 128 words; bytes 1..4, zp=1, scale=2.0 -> 0,2,4,6.
    rd_data = 32'h0403_0201;
    for (int w = 0; w < 128; w++) begin
      push(1'b0, 32'h8000 + 32'(4 * w), 32'h0, 4'hF);
      push(1'b1, 32'hA000 + 32'(8 * w), 32'h0002_0000, 4'hF);
      push(1'b1, 32'hA004 + 32'(8 * w), 32'h0006_0004, 4'hF);
    end
    run_job(32'h0000_0200, 32'h0000_0001, 32'h8000, 32'hA000, 32'd1000, 1'b0);
    check("clamp_cycles", 80'(cycles), 80'(769));
    end_job();

    // Write grant stalled, then reset mid-job.
    stall_wr = 5;
    rd_data = 32'h807F_01FF;
    push(1'b0, 32'h1000, 32'h0, 4'hF);
    push(1'b1, 32'h2000, 32'h0001_FFFF, 4'hF);
    scale_i = 32'h0000_0100; zp_i = 32'h0; src_addr_i = 32'h1000; dst_addr_i = 32'h2000;
    length_i = 32'd4; int_en_i = 1'b1; start_i = 1'b1;
    cycles = 0;
    do begin
      @(negedge clk_i);
      cycles++;
    end while (!(mem_req_o && mem_we_o) && cycles < 50);
    check("stall_write_seen", 80'(mem_req_o && mem_we_o), 80'(1));
    start_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("still_stalled", 80'({busy_o, mem_req_o, mem_we_o}), 80'(3'b111));
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    check_reset_state("mid_job_reset");
    @(negedge clk_i);
    check_reset_state("idle_after_reset");
    stall_wr = 0;
    check("queue_after_reset", 80'(exp_q.size()), 80'(0));

    repeat (3) @(negedge clk_i);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
